// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants and state encoding for the switch bounce generator
package debounce_pkg;

    localparam logic STATE_IDLE   = 1'b0;
    localparam logic STATE_BOUNCE = 1'b1;

    localparam int              LFSR_W       = 16;
    localparam logic [LFSR_W-1:0] TAP_MASK     = 16'hB400;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic {
        ST_IDLE   = STATE_IDLE,
        ST_BOUNCE = STATE_BOUNCE
    } state_t;

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR, shift-left, advances only on request
module lfsr16
    import debounce_pkg::*;
(
    input  logic              clk,
    input  logic              rst_l,
    input  logic              advance,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic feedback;

    // Taps x^16+x^14+x^13+x^11 map onto bits 15,13,12,10 of the shift-left register.
    assign feedback = ^(q & TAP_MASK);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            q <= seed;
        end else if (advance) begin
            q <= {q[LFSR_W-2:0], feedback};
        end
    end

endmodule

// File: rtl/switch_bounce_generator.sv
// rtl/switch_bounce_generator.sv - turns a clean level into a bouncy switch waveform
module switch_bounce_generator
    import debounce_pkg::*;
#(
    parameter int                BOUNCE_CYCLES = 16,
    parameter int                GLITCH_BITS   = 2,
    parameter logic [LFSR_W-1:0] LFSR_SEED     = DEFAULT_SEED
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Enable,
    input  logic i_Clean,
    output logic o_Bouncy,
    output logic o_Busy,
    output logic o_Settled
);

    localparam int WIN_W = $clog2(BOUNCE_CYCLES + 1);
    localparam int SEG_W = (GLITCH_BITS > 0) ? GLITCH_BITS : 1;
    localparam logic [LFSR_W-1:0] SEG_MASK = LFSR_W'((1 << GLITCH_BITS) - 1);
    localparam logic [WIN_W-1:0]  WIN_LOAD = WIN_W'(BOUNCE_CYCLES - 1);

    generate
        if (LFSR_SEED == '0) begin : g_bad_seed
            $error("switch_bounce_generator: LFSR_SEED must be nonzero");
        end
        if (GLITCH_BITS < 0 || GLITCH_BITS > 4) begin : g_bad_glitch
            $error("switch_bounce_generator: GLITCH_BITS must be 0..4");
        end
        if (BOUNCE_CYCLES < 1) begin : g_bad_window
            $error("switch_bounce_generator: BOUNCE_CYCLES must be >= 1");
        end
    endgenerate

    state_t            r_State,   w_State_Next;
    logic              r_Bouncy,  w_Bouncy_Next;
    logic              r_Settled, w_Settled_Next;
    logic              r_Target,  w_Target_Next;
    logic [WIN_W-1:0]  r_Win,     w_Win_Next;
    logic [SEG_W-1:0]  r_Seg,     w_Seg_Next;
    logic              w_Start;
    logic              w_Advance;
    logic [LFSR_W-1:0] w_Lfsr;
    logic [SEG_W-1:0]  w_Seg_Load;

    lfsr16 u_lfsr (
        .clk     (i_Clk),
        .rst_l   (i_Rst_L),
        .advance (w_Advance),
        .seed    (LFSR_SEED),
        .q       (w_Lfsr)
    );

    // With GLITCH_BITS=0 the mask is zero, giving fixed one-clock segments.
    assign w_Seg_Load = SEG_W'(w_Lfsr & SEG_MASK);

    always_comb begin
        w_State_Next   = r_State;
        w_Bouncy_Next  = r_Bouncy;
        w_Settled_Next = 1'b0;
        w_Target_Next  = r_Target;
        w_Win_Next     = r_Win;
        w_Seg_Next     = r_Seg;
        w_Advance      = 1'b0;
        w_Start        = 1'b0;

        case (r_State)
            ST_IDLE: begin
                if (!i_Enable) begin
                    w_Bouncy_Next = i_Clean;
                    w_Target_Next = i_Clean;
                end else if (i_Clean != r_Target) begin
                    w_Start = 1'b1;
                end
            end
            ST_BOUNCE: begin
                if (!i_Enable) begin
                    w_State_Next  = ST_IDLE;
                    w_Bouncy_Next = i_Clean;
                    w_Target_Next = i_Clean;
                end else if (i_Clean != r_Target) begin
                    w_Start = 1'b1;
                end else if (r_Win == '0) begin
                    // Force the final level so toggle parity never matters.
                    w_Bouncy_Next  = r_Target;
                    w_Settled_Next = 1'b1;
                    w_State_Next   = ST_IDLE;
                end else if (r_Seg == '0) begin
                    w_Bouncy_Next = ~r_Bouncy;
                    w_Seg_Next    = w_Seg_Load;
                    w_Advance     = 1'b1;
                    w_Win_Next    = r_Win - WIN_W'(1);
                end else begin
                    w_Seg_Next = r_Seg - SEG_W'(1);
                    w_Win_Next = r_Win - WIN_W'(1);
                end
            end
            default: begin
                w_State_Next = ST_IDLE;
            end
        endcase

        // Entry and retrigger share one path so a new edge always restarts the window.
        if (w_Start) begin
            w_Bouncy_Next = i_Clean;
            w_Target_Next = i_Clean;
            w_Win_Next    = WIN_LOAD;
            w_Seg_Next    = w_Seg_Load;
            w_Advance     = 1'b1;
            w_State_Next  = ST_BOUNCE;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State   <= ST_IDLE;
            r_Bouncy  <= 1'b0;
            r_Settled <= 1'b0;
            r_Target  <= 1'b0;
            r_Win     <= '0;
            r_Seg     <= '0;
        end else begin
            r_State   <= w_State_Next;
            r_Bouncy  <= w_Bouncy_Next;
            r_Settled <= w_Settled_Next;
            r_Target  <= w_Target_Next;
            r_Win     <= w_Win_Next;
            r_Seg     <= w_Seg_Next;
        end
    end

    assign o_Bouncy  = r_Bouncy;
    assign o_Settled = r_Settled;
    assign o_Busy    = (r_State == ST_BOUNCE);

endmodule
